// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: fixed-latency access to 64-bit-wide storage, RV64 load/store sizing.
// Optional build macro DMEM_MISALIGN_CHECK_EN turns misaligned H/W/D accesses into errors instead of aligning them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept, commit;

  logic            wr_p0;
  logic [63:0]     addr_p0;
  logic [63:0]     wdata_p0;
  logic [2:0]      f3_p0;

  logic [63:0]     rdata_p1;
  logic            err_p1;
  logic            vld_p1;

  logic [63:0]     mem [DEPTH_WORDS];

  logic [AW-1:0]   idx;
  logic [2:0]      off, off_al, size_m1;
  logic            range_err, f3_err, mis_err, acc_err;
  logic [63:0]     word_rd, ld_data, st_word;

  // Sign- or zero-extend the right-aligned loaded bytes according to funct3.
  function automatic logic [63:0] ext_load(input logic [63:0] w, input logic [2:0] f3);
    logic [63:0] r;
    case (f3)
      3'b000:  r = 64'($signed(w[7:0]));
      3'b001:  r = 64'($signed(w[15:0]));
      3'b010:  r = 64'($signed(w[31:0]));
      3'b100:  r = {56'd0, w[7:0]};
      3'b101:  r = {48'd0, w[15:0]};
      3'b110:  r = {32'd0, w[31:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed bytes of the old word with the shifted store data.
  function automatic logic [63:0] merge_store(input logic [63:0] old_w, input logic [63:0] wd,
                                              input logic [1:0] sz, input logic [2:0] ofs);
    logic [7:0]  be;
    logic [63:0] mask;
    case (sz)
      2'd0:    be = 8'h01;
      2'd1:    be = 8'h03;
      2'd2:    be = 8'h0F;
      default: be = 8'hFF;
    endcase
    be = be << ofs;
    for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{be[i]}};
    return (old_w & ~mask) | ((wd << {ofs, 3'b000}) & mask);
  endfunction

  assign accept    = req_valid & req_ready;
  assign commit    = (state == BUSY) && (cnt == '0) && !rst;
  assign req_ready = ((state == IDLE) || (state == RESP)) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) cnt_nxt   = cnt - 1'b1;
        else           state_nxt = RESP;
      end
      RESP: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= req_write;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
      f3_p0    <= req_funct3;
    end
  end

  assign idx       = addr_p0[3 +: AW];
  assign off       = addr_p0[2:0];
  assign range_err = (addr_p0 >> (AW + 3)) != 64'd0;
  assign f3_err    = wr_p0 ? f3_p0[2] : (f3_p0 == 3'b111);

  always_comb begin
    case (f3_p0[1:0])
      2'd0:    size_m1 = 3'd0;
      2'd1:    size_m1 = 3'd1;
      2'd2:    size_m1 = 3'd3;
      default: size_m1 = 3'd7;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_err = |(off & size_m1);
  assign off_al  = off;
`else
  assign mis_err = 1'b0;
  assign off_al  = off & ~size_m1;
`endif

  assign acc_err = range_err | f3_err | mis_err;
  assign word_rd = mem[idx];
  assign ld_data = ext_load(word_rd >> {off_al, 3'b000}, f3_p0);
  assign st_word = merge_store(word_rd, wdata_p0, f3_p0[1:0], off_al);

  always_ff @(posedge clk) begin
    if (commit && wr_p0 && !acc_err) mem[idx] <= st_word;
  end

  // p1: response registered at the commit edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (commit) begin
      rdata_p1 <= (acc_err || wr_p0) ? 64'd0 : ld_data;
      err_p1   <= acc_err;
    end
  end

  assign vld_p1    = (state == RESP);
  assign rsp_valid = vld_p1;
  assign rsp_rdata = rdata_p1;
  assign rsp_error = err_p1;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=512, LATENCY=2); expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_error;

  int errors = 0;
  int checks = 0;

  dmem_responder #(.DEPTH_WORDS(512), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  // One transaction; lat counts negedges after the accept edge until rsp_valid (-1 if none).
  task automatic do_req(input logic wr, input logic [63:0] a, input logic [63:0] wd,
                        input logic [2:0] f3, output logic [63:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; er = rsp_error;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_rdata !== 64'd0 || rsp_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b rdy=%b rd=%h er=%b, want 0 0 0 0", rsp_valid, req_ready, rsp_rdata, rsp_error);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: rdy=%b want 1", req_ready);
    end
  endtask

  task automatic test_basic;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b1, 64'h40, 64'h1122334455667788, 3'b011, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 64'd0) begin
      errors++;
      $display("FAIL sd_40: lat=%0d er=%b rd=%h, want lat=3 er=0 rd=0", lat, er, rd);
    end
    do_req(1'b0, 64'h40, 64'd0, 3'b011, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0 || rd !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL ld_40: lat=%0d er=%b rd=%h, want lat=3 er=0 rd=1122334455667788", lat, er, rd);
    end
  endtask

  task automatic test_subword;
    logic [63:0] rd; logic er; int lat;
    logic [63:0] la [6];
    logic [2:0]  lf [6];
    logic [63:0] le [6];
    la[0] = 64'h13; lf[0] = 3'b000; le[0] = 64'hFFFFFFFFFFFFFF80;
    la[1] = 64'h13; lf[1] = 3'b100; le[1] = 64'h0000000000000080;
    la[2] = 64'h10; lf[2] = 3'b010; le[2] = 64'hFFFFFFFF80DDEEFF;
    la[3] = 64'h12; lf[3] = 3'b001; le[3] = 64'hFFFFFFFFFFFF80DD;
    la[4] = 64'h16; lf[4] = 3'b101; le[4] = 64'h0000000000008899;
    la[5] = 64'h14; lf[5] = 3'b110; le[5] = 64'h000000008899AABB;
    do_req(1'b1, 64'h10, 64'h8899AABBCCDDEEFF, 3'b011, rd, er, lat);
    do_req(1'b1, 64'h13, 64'h1234567890ABCD80, 3'b000, rd, er, lat);
    checks++;
    if (lat !== 3 || er !== 1'b0) begin
      errors++;
      $display("FAIL sb_13: lat=%0d er=%b, want lat=3 er=0", lat, er);
    end
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, la[i], 64'd0, lf[i], rd, er, lat);
      checks++;
      if (rd !== le[i] || er !== 1'b0 || lat !== 3) begin
        errors++;
        $display("FAIL subload_%0d: addr=%h f3=%b rd=%h er=%b lat=%0d, want rd=%h er=0 lat=3",
                 i, la[i], lf[i], rd, er, lat, le[i]);
      end
    end
    do_req(1'b1, 64'h14, 64'hFFFFFFFFFFFF1234, 3'b001, rd, er, lat);
    do_req(1'b0, 64'h10, 64'd0, 3'b011, rd, er, lat);
    checks++;
    if (rd !== 64'h8899123480DDEEFF || er !== 1'b0) begin
      errors++;
      $display("FAIL sh_merge: rd=%h er=%b, want 8899123480DDEEFF er=0", rd, er);
    end
  endtask

  task automatic test_errors;
    logic [63:0] rd; logic er; int lat;
    do_req(1'b0, 64'h1000, 64'd0, 3'b011, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0 || lat !== 3) begin
      errors++;
      $display("FAIL ld_out_of_range: er=%b rd=%h lat=%0d, want er=1 rd=0 lat=3", er, rd, lat);
    end
    do_req(1'b1, 64'hFF8, 64'hA5A55A5A0F0FF0F0, 3'b011, rd, er, lat);
    do_req(1'b0, 64'hFF8, 64'd0, 3'b011, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 64'hA5A55A5A0F0FF0F0) begin
      errors++;
      $display("FAIL ld_last_word: er=%b rd=%h, want er=0 rd=A5A55A5A0F0FF0F0", er, rd);
    end
    do_req(1'b0, 64'h40, 64'd0, 3'b111, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL ld_f3_111: er=%b rd=%h, want er=1 rd=0", er, rd);
    end
    do_req(1'b1, 64'h40, 64'd0, 3'b100, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 64'd0) begin
      errors++;
      $display("FAIL st_f3_100: er=%b rd=%h, want er=1 rd=0", er, rd);
    end
    do_req(1'b0, 64'h40, 64'd0, 3'b011, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL mem_unchanged: er=%b rd=%h, want er=0 rd=1122334455667788", er, rd);
    end
  endtask

  task automatic test_misalign;
    logic [63:0] rd; logic er; int lat;
    logic [63:0] exp_rd; logic exp_er;
`ifdef DMEM_MISALIGN_CHECK_EN
    exp_rd = 64'd0; exp_er = 1'b1;
`else
    exp_rd = 64'h0000000055667788; exp_er = 1'b0;
`endif
    do_req(1'b0, 64'h42, 64'd0, 3'b010, rd, er, lat);
    checks++;
    if (rd !== exp_rd || er !== exp_er) begin
      errors++;
      $display("FAIL lw_42: rd=%h er=%b, want rd=%h er=%b", rd, er, exp_rd, exp_er);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a [4];
    logic [63:0] e [4];
    int acc_cyc [4];
    int idx, nrsp, last_acc;
    logic acc;
    a[0] = 64'h40;  e[0] = 64'h1122334455667788;
    a[1] = 64'h10;  e[1] = 64'h8899123480DDEEFF;
    a[2] = 64'hFF8; e[2] = 64'hA5A55A5A0F0FF0F0;
    a[3] = 64'h40;  e[3] = 64'h1122334455667788;
    idx = 0; nrsp = 0; last_acc = -10;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b011; req_addr = a[0];
    for (int cyc = 0; cyc < 40 && nrsp < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc - last_acc == 1 || cyc - last_acc == 2) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_busy: cyc=%0d rdy=%b want 0", cyc, req_ready);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (rsp_rdata !== e[nrsp] || rsp_error !== 1'b0 || cyc - acc_cyc[nrsp] !== 3) begin
          errors++;
          $display("FAIL b2b_rsp_%0d: rd=%h er=%b dist=%0d, want rd=%h er=0 dist=3",
                   nrsp, rsp_rdata, rsp_error, cyc - acc_cyc[nrsp], e[nrsp]);
        end
        nrsp++;
      end
      acc = req_ready && req_valid && (idx < 4);
      if (acc) begin
        if (idx > 0) begin
          checks++;
          if (cyc - acc_cyc[idx-1] !== 3) begin
            errors++;
            $display("FAIL b2b_accept_gap_%0d: gap=%0d want 3", idx, cyc - acc_cyc[idx-1]);
          end
        end
        acc_cyc[idx] = cyc;
        last_acc = cyc;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) req_addr = a[idx];
        else         req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nrsp !== 4) begin
      errors++;
      $display("FAIL b2b_count: responses=%0d want 4", nrsp);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] rd; logic er; int lat;
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h40; req_wdata = 64'hDEADBEEF; req_funct3 = 3'b010;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_cancel: rsp_valid pulses=%0d want 0", seen);
    end
    do_req(1'b0, 64'h40, 64'd0, 3'b010, rd, er, lat);
    checks++;
    if (rd !== 64'h0000000055667788 || er !== 1'b0 || lat !== 3) begin
      errors++;
      $display("FAIL store_dropped: rd=%h er=%b lat=%0d, want rd=0000000055667788 er=0 lat=3", rd, er, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_subword();
    test_errors();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
